// File: rtl/x86_prefetch_queue.sv
// Instruction prefetch queue: runs CS:IP fetches ahead of the decoder and presents bytes with their IP.
// Optional PFQ_PEEK2_EN adds a second-byte peek and a two-byte take.
module x86_prefetch_queue #(
  parameter int          BUS_BYTES = 1,
  parameter int          DEPTH     = 8,
  parameter int          ADDR_W    = 20,
  parameter logic [15:0] RESET_CS  = 16'hF000,
  parameter logic [15:0] RESET_IP  = 16'hFFF0
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [ADDR_W-1:0]        mem_address,
  output logic                     mem_rd,
  input  logic [8*BUS_BYTES-1:0]   mem_data,
  input  logic                     mem_ready,
  input  logic                     flush,
  input  logic [15:0]              flush_cs,
  input  logic [15:0]              flush_ip,
  output logic [7:0]               q_byte,
  output logic                     q_valid,
  output logic [15:0]              q_ip,
  input  logic                     q_take,
`ifdef PFQ_PEEK2_EN
  output logic [7:0]               q_byte1,
  output logic                     q_valid1,
  input  logic                     q_take2,
`endif
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (ADDR_W > 20) ? ADDR_W : 20;

  typedef enum logic {IDLE, REQ} state_t;

  state_t          state_q, state_d;
  logic [7:0]      buf_q [DEPTH];
  logic [7:0]      buf_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     fetch_ip_q, fetch_ip_d, head_ip_q, head_ip_d, cs_q, cs_d;

  logic            fill, take_one, take_two, space_ok;
  logic [1:0]      written, taken;
  logic [15:0]     ip_aligned;
  logic [SW-1:0]   linear;
  logic [7:0]      lo_byte, hi_byte;

  // An odd IP on a word bus delivers only the upper byte of the aligned word.
  function automatic logic [1:0] bytes_for(input logic [15:0] ip);
    if (BUS_BYTES == 1) return 2'd1;
    return ip[0] ? 2'd1 : 2'd2;
  endfunction

  assign lo_byte = mem_data[7:0];
  assign hi_byte = mem_data[8*BUS_BYTES-1 -: 8];

  always_comb begin
    ip_aligned = fetch_ip_q;
    if (BUS_BYTES == 2) ip_aligned[0] = 1'b0;
    linear      = SW'({cs_q, 4'b0000}) + SW'(ip_aligned);
    mem_address = linear[ADDR_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fetch_ip_d = fetch_ip_q;
    head_ip_d  = head_ip_q;
    cs_d       = cs_q;
    space_ok   = 1'b0;

    fill     = (state_q == REQ) && mem_ready && !flush;
    written  = fill ? bytes_for(fetch_ip_q) : 2'd0;
    take_one = q_take && (count_q != '0);
`ifdef PFQ_PEEK2_EN
    take_two = q_take2 && (count_q >= CW'(2));
`else
    take_two = 1'b0;
`endif
    taken = take_two ? 2'd2 : (take_one ? 2'd1 : 2'd0);

    if (fill) begin
      if (BUS_BYTES == 2 && fetch_ip_q[0]) begin
        buf_d[wr_ptr_q] = hi_byte;
      end else begin
        buf_d[wr_ptr_q] = lo_byte;
        if (BUS_BYTES == 2) buf_d[PW'(wr_ptr_q + 1'b1)] = hi_byte;
      end
    end

    wr_ptr_d   = wr_ptr_q + PW'(written);
    fetch_ip_d = fetch_ip_q + 16'(written);
    rd_ptr_d   = rd_ptr_q + PW'(taken);
    head_ip_d  = head_ip_q + 16'(taken);
    count_d    = count_q + CW'(written) - CW'(taken);

    // Space is judged against the post-update count, so a held request can never overflow.
    space_ok = (CW'(DEPTH) - count_d) >= CW'(bytes_for(fetch_ip_d));

    case (state_q)
      IDLE:    if (space_ok) state_d = REQ;
      REQ:     if (mem_ready) state_d = space_ok ? REQ : IDLE;
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d    = IDLE;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      cs_d       = flush_cs;
      fetch_ip_d = flush_ip;
      head_ip_d  = flush_ip;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fetch_ip_q <= RESET_IP;
      head_ip_q  <= RESET_IP;
      cs_q       <= RESET_CS;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fetch_ip_q <= fetch_ip_d;
      head_ip_q  <= head_ip_d;
      cs_q       <= cs_d;
    end
  end

  // Storage needs no reset: outputs are gated by the count.
  always_ff @(posedge clock) begin
    buf_q <= buf_d;
  end

  assign mem_rd  = (state_q == REQ);
  assign q_valid = (count_q != '0);
  assign q_byte  = q_valid ? buf_q[rd_ptr_q] : 8'h00;
  assign q_ip    = head_ip_q;
  assign q_count = count_q;
`ifdef PFQ_PEEK2_EN
  assign q_valid1 = (count_q >= CW'(2));
  assign q_byte1  = q_valid1 ? buf_q[PW'(rd_ptr_q + 1'b1)] : 8'h00;
`endif

endmodule

// File: tb/tb_x86_prefetch_queue.sv
// Directed bench for x86_prefetch_queue: one byte-bus and one word-bus instance with a simple memory model.
module tb_x86_prefetch_queue;

  logic        clock = 1'b0;
  logic        reset;

  logic [19:0] a_addr;
  logic        a_rd;
  logic [7:0]  a_data;
  logic        a_ready, a_flush, a_take;
  logic [15:0] a_fcs, a_fip, a_ip;
  logic [7:0]  a_byte;
  logic        a_valid;
  logic [3:0]  a_count;

  logic [19:0] b_addr;
  logic        b_rd;
  logic [15:0] b_data;
  logic        b_ready, b_flush, b_take;
  logic [15:0] b_fcs, b_fip, b_ip;
  logic [7:0]  b_byte;
  logic        b_valid;
  logic [3:0]  b_count;

`ifdef PFQ_PEEK2_EN
  logic [7:0]  a_byte1, b_byte1;
  logic        a_valid1, b_valid1, a_take2, b_take2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  function automatic logic [7:0] byte_at(input logic [19:0] a);
    return a[7:0] ^ {a[11:8], a[19:16]} ^ 8'hA5;
  endfunction

  function automatic logic [19:0] phys(input logic [15:0] cs, input logic [15:0] ip);
    return {cs, 4'b0000} + {4'b0000, ip};
  endfunction

  assign a_data = byte_at(a_addr);
  assign b_data = {byte_at(b_addr + 20'd1), byte_at(b_addr)};

  x86_prefetch_queue #(.BUS_BYTES(1), .DEPTH(8)) dut_a (
    .clock(clock), .reset(reset), .mem_address(a_addr), .mem_rd(a_rd), .mem_data(a_data),
    .mem_ready(a_ready), .flush(a_flush), .flush_cs(a_fcs), .flush_ip(a_fip),
    .q_byte(a_byte), .q_valid(a_valid), .q_ip(a_ip), .q_take(a_take),
`ifdef PFQ_PEEK2_EN
    .q_byte1(a_byte1), .q_valid1(a_valid1), .q_take2(a_take2),
`endif
    .q_count(a_count)
  );

  x86_prefetch_queue #(.BUS_BYTES(2), .DEPTH(8)) dut_b (
    .clock(clock), .reset(reset), .mem_address(b_addr), .mem_rd(b_rd), .mem_data(b_data),
    .mem_ready(b_ready), .flush(b_flush), .flush_cs(b_fcs), .flush_ip(b_fip),
    .q_byte(b_byte), .q_valid(b_valid), .q_ip(b_ip), .q_take(b_take),
`ifdef PFQ_PEEK2_EN
    .q_byte1(b_byte1), .q_valid1(b_valid1), .q_take2(b_take2),
`endif
    .q_count(b_count)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    checks++; if (a_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd: got %b expected 0", a_rd); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", a_valid); end
    checks++; if (a_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", a_count); end
    checks++; if (a_byte !== 8'h00) begin errors++; $display("[TB] FAIL reset_byte: got %h expected 00", a_byte); end
    checks++; if (a_ip !== 16'hFFF0) begin errors++; $display("[TB] FAIL reset_ip: got %h expected FFF0", a_ip); end
    reset = 1'b0;
    step();
    checks++; if (a_rd !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_rd: got %b expected 1", a_rd); end
    checks++; if (a_addr !== 20'hFFFF0) begin errors++; $display("[TB] FAIL reset_vector: got %h expected FFFF0", a_addr); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_valid: got %b expected 0", a_valid); end
    checks++; if (b_addr !== 20'hFFFF0) begin errors++; $display("[TB] FAIL reset_vector_word: got %h expected FFFF0", b_addr); end
  endtask

  task automatic test_fill_to_full();
    int accepted = 0;
    a_ready = 1'b1;
    repeat (12) begin
      if (a_rd) accepted++;
      step();
    end
    checks++; if (accepted != 8) begin errors++; $display("[TB] FAIL fill_fetches: got %0d expected 8", accepted); end
    checks++; if (a_count !== 4'd8) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 8", a_count); end
    checks++; if (a_rd !== 1'b0) begin errors++; $display("[TB] FAIL fill_rd: got %b expected 0", a_rd); end
    checks++; if (a_byte !== byte_at(20'hFFFF0)) begin errors++; $display("[TB] FAIL fill_head: got %h expected %h", a_byte, byte_at(20'hFFFF0)); end
    a_take = 1'b1;
    step();
    a_take = 1'b0;
    checks++; if (a_count !== 4'd7) begin errors++; $display("[TB] FAIL take_count: got %0d expected 7", a_count); end
    checks++; if (a_rd !== 1'b1) begin errors++; $display("[TB] FAIL take_rd: got %b expected 1", a_rd); end
    checks++; if (a_ip !== 16'hFFF1) begin errors++; $display("[TB] FAIL take_ip: got %h expected FFF1", a_ip); end
    step();
    checks++; if (a_count !== 4'd8) begin errors++; $display("[TB] FAIL refill_count: got %0d expected 8", a_count); end
    checks++; if (a_rd !== 1'b0) begin errors++; $display("[TB] FAIL refill_rd: got %b expected 0", a_rd); end
  endtask

  task automatic test_concurrent();
    logic [15:0] exp_ip = 16'hFFF1;
    a_take  = 1'b1;
    a_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      checks++; if (a_ip !== exp_ip) begin errors++; $display("[TB] FAIL flow_ip[%0d]: got %h expected %h", i, a_ip, exp_ip); end
      checks++; if (a_byte !== byte_at(phys(16'hF000, exp_ip))) begin errors++; $display("[TB] FAIL flow_byte[%0d]: got %h expected %h", i, a_byte, byte_at(phys(16'hF000, exp_ip))); end
      step();
      exp_ip = exp_ip + 16'd1;
    end
    checks++; if (a_count !== 4'd7) begin errors++; $display("[TB] FAIL flow_count: got %0d expected 7", a_count); end
    a_take  = 1'b0;
    a_ready = 1'b0;
    step();
  endtask

  task automatic test_flush_in_flight();
    checks++; if (a_rd !== 1'b1) begin errors++; $display("[TB] FAIL preflush_rd: got %b expected 1", a_rd); end
    a_flush = 1'b1; a_fcs = 16'h1234; a_fip = 16'h0010; a_ready = 1'b1; a_take = 1'b1;
    step();
    a_flush = 1'b0; a_ready = 1'b0;
    checks++; if (a_count !== 4'd0) begin errors++; $display("[TB] FAIL flush_count: got %0d expected 0", a_count); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid: got %b expected 0", a_valid); end
    checks++; if (a_rd !== 1'b0) begin errors++; $display("[TB] FAIL flush_rd_low: got %b expected 0", a_rd); end
    checks++; if (a_ip !== 16'h0010) begin errors++; $display("[TB] FAIL flush_ip: got %h expected 0010", a_ip); end
    step();
    a_take = 1'b0;
    checks++; if (a_rd !== 1'b1) begin errors++; $display("[TB] FAIL flush_rd_again: got %b expected 1", a_rd); end
    checks++; if (a_addr !== 20'h12350) begin errors++; $display("[TB] FAIL flush_addr: got %h expected 12350", a_addr); end
    checks++; if (a_count !== 4'd0) begin errors++; $display("[TB] FAIL empty_take_count: got %0d expected 0", a_count); end
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    checks++; if (a_count !== 4'd1) begin errors++; $display("[TB] FAIL postflush_count: got %0d expected 1", a_count); end
    checks++; if (a_byte !== byte_at(20'h12350)) begin errors++; $display("[TB] FAIL postflush_byte: got %h expected %h", a_byte, byte_at(20'h12350)); end
    checks++; if (a_ip !== 16'h0010) begin errors++; $display("[TB] FAIL postflush_ip: got %h expected 0010", a_ip); end
  endtask

  task automatic test_odd_ip();
    b_flush = 1'b1; b_fcs = 16'h0000; b_fip = 16'h0003; b_ready = 1'b0;
    step();
    b_flush = 1'b0;
    checks++; if (b_rd !== 1'b0) begin errors++; $display("[TB] FAIL odd_rd_low: got %b expected 0", b_rd); end
    step();
    checks++; if (b_addr !== 20'h00002) begin errors++; $display("[TB] FAIL odd_addr: got %h expected 00002", b_addr); end
    b_ready = 1'b1;
    step();
    checks++; if (b_count !== 4'd1) begin errors++; $display("[TB] FAIL odd_count: got %0d expected 1", b_count); end
    checks++; if (b_byte !== byte_at(20'h00003)) begin errors++; $display("[TB] FAIL odd_byte: got %h expected %h", b_byte, byte_at(20'h00003)); end
    checks++; if (b_ip !== 16'h0003) begin errors++; $display("[TB] FAIL odd_ip: got %h expected 0003", b_ip); end
    checks++; if (b_addr !== 20'h00004) begin errors++; $display("[TB] FAIL aligned_addr: got %h expected 00004", b_addr); end
    step();
    b_ready = 1'b0;
    checks++; if (b_count !== 4'd3) begin errors++; $display("[TB] FAIL aligned_count: got %0d expected 3", b_count); end
  endtask

  task automatic test_segment_wrap();
    b_flush = 1'b1; b_fcs = 16'h2000; b_fip = 16'hFFFE; b_ready = 1'b0;
    step();
    b_flush = 1'b0;
    step();
    checks++; if (b_addr !== 20'h2FFFE) begin errors++; $display("[TB] FAIL wrap_addr0: got %h expected 2FFFE", b_addr); end
    b_ready = 1'b1;
    step();
    checks++; if (b_addr !== 20'h20000) begin errors++; $display("[TB] FAIL wrap_addr1: got %h expected 20000", b_addr); end
    step();
    b_ready = 1'b0;
    checks++; if (b_count !== 4'd4) begin errors++; $display("[TB] FAIL wrap_count: got %0d expected 4", b_count); end
    checks++; if (b_ip !== 16'hFFFE) begin errors++; $display("[TB] FAIL wrap_ip0: got %h expected FFFE", b_ip); end
    checks++; if (b_byte !== byte_at(20'h2FFFE)) begin errors++; $display("[TB] FAIL wrap_byte0: got %h expected %h", b_byte, byte_at(20'h2FFFE)); end
`ifdef PFQ_PEEK2_EN
    checks++; if (b_byte1 !== byte_at(20'h2FFFF)) begin errors++; $display("[TB] FAIL wrap_peek1: got %h expected %h", b_byte1, byte_at(20'h2FFFF)); end
    b_take2 = 1'b1; b_take = 1'b1;
    step();
    b_take2 = 1'b0; b_take = 1'b0;
`else
    b_take = 1'b1;
    step();
    checks++; if (b_ip !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_ip1: got %h expected FFFF", b_ip); end
    checks++; if (b_byte !== byte_at(20'h2FFFF)) begin errors++; $display("[TB] FAIL wrap_byte1: got %h expected %h", b_byte, byte_at(20'h2FFFF)); end
    step();
    b_take = 1'b0;
`endif
    checks++; if (b_ip !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_ip2: got %h expected 0000", b_ip); end
    checks++; if (b_byte !== byte_at(20'h20000)) begin errors++; $display("[TB] FAIL wrap_byte2: got %h expected %h", b_byte, byte_at(20'h20000)); end
    checks++; if (b_count !== 4'd2) begin errors++; $display("[TB] FAIL wrap_count_after: got %0d expected 2", b_count); end
  endtask

  initial begin
    reset = 1'b1;
    a_ready = 1'b0; a_flush = 1'b0; a_take = 1'b0; a_fcs = 16'h0; a_fip = 16'h0;
    b_ready = 1'b0; b_flush = 1'b0; b_take = 1'b0; b_fcs = 16'h0; b_fip = 16'h0;
`ifdef PFQ_PEEK2_EN
    a_take2 = 1'b0; b_take2 = 1'b0;
`endif
    test_reset();
    test_fill_to_full();
    test_concurrent();
    test_flush_in_flight();
    test_odd_ip();
    test_segment_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
